// File: rtl/fixed_memory_pkg.sv
// Shared types and constants for the load/store front end.
package fixed_memory_pkg;

  localparam int MEMADDRBITS = 10;
  localparam int MEMWORDS    = 1024;

  // Struct field widths; the top-level width parameters default to these
  // and must be left equal to them.
  localparam int DATAW = 16;
  localparam int REGW  = 4;

  typedef struct packed {
    logic             valid;
    logic             is_store;
    logic [DATAW-1:0] ea;
    logic [DATAW-1:0] store_data;
    logic [REGW-1:0]  dest_reg;
  } mem_req_t;

  typedef struct packed {
    logic [REGW-1:0]  dest_reg;
    logic [DATAW-1:0] data;
    logic             fault;
  } wb_entry_t;

  // Any address bit above the memory index makes the access out of range.
  function automatic logic addrInRange(input logic [DATAW-1:0] ea);
    return (ea >> MEMADDRBITS) == '0;
  endfunction

endpackage

// File: rtl/fixed_memory_access_unit_wb_fifo.sv
// Synchronous FIFO holding load results on their way to writeback.
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     pushData,
  output T     headData,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  T               entries [DEPTH];
  logic [PW-1:0]  wrPtr, rdPtr;
  logic [PW:0]    count;
  logic           doPush, doPop;

  assign full     = count == (PW+1)'(DEPTH);
  assign empty    = count == '0;
  assign headData = entries[rdPtr];
  assign doPop    = pop && !empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign doPush   = push && (!full || doPop);

  // Entry storage carries no reset; count alone says what is live.
  always_ff @(posedge clk) begin
    if (doPush) entries[wrPtr] <= pushData;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
    end
  end

endmodule

// File: rtl/fixed_memory_access_unit.sv
// Load/store front end for the fixed 1024-word data memory: one request
// register feeding the memory, load results returned through a FIFO.
module fixed_memory_access_unit
  import fixed_memory_pkg::*;
#(
  parameter int DATABITWIDTH    = DATAW,
  parameter int REGADDRBITWIDTH = REGW,
  parameter int WBQUEUEDEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic                       ReqValid,
  output logic                       ReqReady,
  input  logic                       ReqIsStore,
  input  logic [DATABITWIDTH-1:0]    ReqBase,
  input  logic [DATABITWIDTH-1:0]    ReqOffset,
  input  logic [DATABITWIDTH-1:0]    ReqStoreData,
  input  logic [REGADDRBITWIDTH-1:0] ReqDestReg,
  output logic                       MemWriteEn,
  output logic [DATABITWIDTH-1:0]    MemAddr,
  output logic [DATABITWIDTH-1:0]    MemDataOut,
  input  logic [DATABITWIDTH-1:0]    MemDataIn,
  output logic                       WbValid,
  input  logic                       WbReady,
  output logic [REGADDRBITWIDTH-1:0] WbDestReg,
  output logic [DATABITWIDTH-1:0]    WbData,
  output logic                       WbFault,
  output logic                       StoreFault
);

  mem_req_t  rr;
  wb_entry_t pushEntry, head;
  logic      full, empty, pop, push;
  logic      rrInRange, canRetire, retire, accept, storeFaultQ;

  assign rrInRange = addrInRange(rr.ea);

  // Stores always retire; loads need FIFO room, which a same-edge pop
  // provides even when full (full implies non-empty).
  assign canRetire = rr.valid && (rr.is_store || !full || WbReady);
  assign ReqReady  = !rr.valid || canRetire;
  assign accept    = clk_en && ReqValid && ReqReady;
  assign retire    = clk_en && canRetire;
  assign push      = retire && !rr.is_store;
  assign pop       = clk_en && !empty && WbReady;

  // Out-of-range loads return zero data flagged as a fault.
  always_comb begin
    pushEntry          = '0;
    pushEntry.dest_reg = rr.dest_reg;
    pushEntry.data     = rrInRange ? MemDataIn : '0;
    pushEntry.fault    = !rrInRange;
  end

  // Request register: new request replaces a retiring one in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= '0;
    end else if (accept) begin
      rr.valid      <= 1'b1;
      rr.is_store   <= ReqIsStore;
      rr.ea         <= ReqBase + ReqOffset;
      rr.store_data <= ReqStoreData;
      rr.dest_reg   <= ReqDestReg;
    end else if (retire) begin
      rr.valid <= 1'b0;
    end
  end

  // One-cycle flag for a store dropped on an out-of-range address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) storeFaultQ <= 1'b0;
    else     storeFaultQ <= retire && rr.is_store && !rrInRange;
  end

  // The memory commits whenever write-enable is high on an edge, so the
  // enable itself must carry the clk_en qualification.
  assign MemWriteEn = rr.valid && rr.is_store && rrInRange && clk_en;
  assign MemAddr    = rr.valid ? rr.ea : '0;
  assign MemDataOut = rr.valid ? rr.store_data : '0;
  assign StoreFault = storeFaultQ && clk_en;

  wb_fifo #(
    .DEPTH (WBQUEUEDEPTH),
    .T     (wb_entry_t)
  ) uWbFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .pushData (pushEntry),
    .headData (head),
    .full     (full),
    .empty    (empty)
  );

  assign WbValid   = !empty;
  assign WbDestReg = empty ? '0 : head.dest_reg;
  assign WbData    = empty ? '0 : head.data;
  assign WbFault   = !empty && head.fault;

endmodule

// File: tb/tb_fixed_memory_access_unit.sv
// Directed bench: table of single requests plus backpressure, clk_en and
// mid-operation reset sequences, against a behavioural 1024-word memory.
module tb_fixed_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst, clk_en, ReqValid, ReqReady, ReqIsStore;
  logic [15:0] ReqBase, ReqOffset, ReqStoreData;
  logic [3:0]  ReqDestReg;
  logic        MemWriteEn;
  logic [15:0] MemAddr, MemDataOut, MemDataIn;
  logic        WbValid, WbReady, WbFault, StoreFault;
  logic [3:0]  WbDestReg;
  logic [15:0] WbData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_memory_access_unit dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqIsStore(ReqIsStore),
    .ReqBase(ReqBase), .ReqOffset(ReqOffset), .ReqStoreData(ReqStoreData),
    .ReqDestReg(ReqDestReg),
    .MemWriteEn(MemWriteEn), .MemAddr(MemAddr), .MemDataOut(MemDataOut),
    .MemDataIn(MemDataIn),
    .WbValid(WbValid), .WbReady(WbReady), .WbDestReg(WbDestReg),
    .WbData(WbData), .WbFault(WbFault), .StoreFault(StoreFault)
  );

  // Memory model: unwritten words read as 0xA000 | index.
  logic [15:0] memArr [1024];
  bit          memWr  [1024];

  always @(posedge clk) begin
    if (MemWriteEn) begin
      memArr[MemAddr[9:0]] <= MemDataOut;
      memWr[MemAddr[9:0]]  <= 1'b1;
    end
  end

  assign MemDataIn = memWr[MemAddr[9:0]] ? memArr[MemAddr[9:0]]
                                         : (16'hA000 | {6'b0, MemAddr[9:0]});

  function automatic logic [15:0] memRead(input logic [15:0] a);
    logic [9:0] idx;
    idx = a[9:0];
    return memWr[idx] ? memArr[idx] : (16'hA000 | {6'b0, idx});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] b, input logic [15:0] o,
                       input logic [15:0] d, input logic [3:0] r);
    ReqValid = 1'b1; ReqIsStore = st; ReqBase = b; ReqOffset = o;
    ReqStoreData = d; ReqDestReg = r;
  endtask

  typedef struct {
    logic        isStore;
    logic [15:0] base, off, data;
    logic [3:0]  dest;
    logic [15:0] expAddr;
    logic        expWe, expSf;
    logic [15:0] expData;
    logic        expFault;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic acc;
    int   k, got;

    //          st    base      off       data      dst  addr      we    sf    wbdata    fault
    vecs[0] = '{1'b1, 16'h0008, 16'h0008, 16'hBEEF, 4'd0, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 4'd3, 16'h0010, 1'b0, 1'b0, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h0002, 16'h1234, 4'd0, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'h0003, 16'hFFFE, 16'h0000, 4'd5, 16'h0001, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[4] = '{1'b1, 16'h0400, 16'h0000, 16'h5555, 4'd0, 16'h0400, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 4'd7, 16'h0400, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 16'h03FF, 16'h0000, 16'h0000, 4'd9, 16'h03FF, 1'b0, 1'b0, 16'hA3FF, 1'b0};
    vecs[7] = '{1'b0, 16'h8000, 16'h8005, 16'h0000, 4'd1, 16'h0005, 1'b0, 1'b0, 16'hA005, 1'b0};

    rst = 1'b1; clk_en = 1'b1; WbReady = 1'b1;
    ReqValid = 1'b0; ReqIsStore = 1'b0; ReqBase = '0; ReqOffset = '0;
    ReqStoreData = '0; ReqDestReg = '0;

    @(negedge clk);
    chk("rst ReqReady", ReqReady, 1);
    chk("rst MemWriteEn", MemWriteEn, 0);
    chk("rst MemAddr", MemAddr, 0);
    chk("rst MemDataOut", MemDataOut, 0);
    chk("rst WbValid", WbValid, 0);
    chk("rst WbData", WbData, 0);
    chk("rst WbDestReg", WbDestReg, 0);
    chk("rst WbFault", WbFault, 0);
    chk("rst StoreFault", StoreFault, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table: accept, check memory drive, then check retire effects.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].isStore, vecs[i].base, vecs[i].off, vecs[i].data, vecs[i].dest);
      chk($sformatf("v%0d ReqReady", i), ReqReady, 1);
      @(posedge clk);
      @(negedge clk);
      ReqValid = 1'b0;
      chk($sformatf("v%0d MemAddr", i), MemAddr, vecs[i].expAddr);
      chk($sformatf("v%0d MemWriteEn", i), MemWriteEn, vecs[i].expWe);
      chk($sformatf("v%0d WbValid early", i), WbValid, 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d MemWriteEn after", i), MemWriteEn, 0);
      chk($sformatf("v%0d StoreFault", i), StoreFault, vecs[i].expSf);
      chk($sformatf("v%0d WbValid", i), WbValid, !vecs[i].isStore);
      if (!vecs[i].isStore) begin
        chk($sformatf("v%0d WbDestReg", i), WbDestReg, vecs[i].dest);
        chk($sformatf("v%0d WbData", i), WbData, vecs[i].expData);
        chk($sformatf("v%0d WbFault", i), WbFault, vecs[i].expFault);
      end
    end
    chk("oor store no alias", memRead(16'h0000), 16'hA000);
    chk("mem 0x10", memRead(16'h0010), 16'hBEEF);
    chk("mem 0x01", memRead(16'h0001), 16'h1234);
    @(negedge clk);

    // Backpressure: six loads into a 4-deep FIFO with the consumer stalled.
    WbReady = 1'b0;
    k = 0;
    drive(1'b0, 16'h0020, 16'h0000, 16'h0000, 4'd0);
    for (int c = 0; c < 8; c++) begin
      acc = ReqValid && ReqReady;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        k++;
        if (k < 6) drive(1'b0, 16'h0020 + 16'(k), 16'h0000, 16'h0000, 4'(k));
        else ReqValid = 1'b0;
      end
    end
    chk("bp accepted", k, 5);
    chk("bp ReqReady stalled", ReqReady, 0);
    chk("bp WbValid", WbValid, 1);
    chk("bp head dest", WbDestReg, 0);
    WbReady = 1'b1;
    #1;
    chk("bp ReqReady on pop", ReqReady, 1);
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (WbValid) begin
        chk($sformatf("drain%0d dest", got), WbDestReg, got);
        chk($sformatf("drain%0d data", got), WbData, 16'hA020 + 16'(got));
        got++;
      end
      acc = ReqValid && ReqReady;
      @(posedge clk);
      @(negedge clk);
      if (acc) ReqValid = 1'b0;
    end
    chk("drain count", got, 6);
    chk("drain empty", WbValid, 0);

    // clk_en low with a store in RR and another request waiting.
    drive(1'b1, 16'h0030, 16'h0000, 16'h7777, 4'd0);
    @(posedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    drive(1'b1, 16'h0031, 16'h0000, 16'h1111, 4'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d MemWriteEn", c), MemWriteEn, 0);
      chk($sformatf("hold%0d MemAddr", c), MemAddr, 16'h0030);
      chk($sformatf("hold%0d StoreFault", c), StoreFault, 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d mem", c), memRead(16'h0030), 16'hA030);
    end
    clk_en = 1'b1;
    #1;
    chk("resume MemWriteEn", MemWriteEn, 1);
    @(posedge clk);
    @(negedge clk);
    ReqValid = 1'b0;
    chk("resume mem 0x30", memRead(16'h0030), 16'h7777);
    chk("resume second accept", MemAddr, 16'h0031);
    chk("resume second we", MemWriteEn, 1);
    @(posedge clk);
    @(negedge clk);
    chk("resume mem 0x31", memRead(16'h0031), 16'h1111);

    // Asynchronous reset with a pending store and two queued loads.
    WbReady = 1'b0;
    drive(1'b0, 16'h0040, 16'h0000, 16'h0000, 4'd1);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 16'h0041, 16'h0000, 16'h0000, 4'd2);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 16'h0042, 16'h0000, 16'hDEAD, 4'd0);
    @(posedge clk); @(negedge clk);
    ReqValid = 1'b0;
    chk("pre-rst WbValid", WbValid, 1);
    chk("pre-rst MemWriteEn", MemWriteEn, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst WbValid", WbValid, 0);
    chk("arst MemWriteEn", MemWriteEn, 0);
    chk("arst MemAddr", MemAddr, 0);
    chk("arst ReqReady", ReqReady, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    WbReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("arst mem 0x42", memRead(16'h0042), 16'hA042);
    chk("arst WbValid after", WbValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_memory_access_unit.md
Name: fixed_memory_access_unit

Overview:
- Load/store front end that sits directly upstream of the fixed 1024-word data memory.
- Accepts in-order load/store requests from the execute stage over a valid/ready handshake.
- Forms the effective address, drives the memory's write-enable, address and data, and captures combinational read data.
- Returns load results to register-file writeback through a small FIFO, with backpressure.

Parameters:
- DATABITWIDTH, 16, data and address word width.
- REGADDRBITWIDTH, 4, destination register index width.
- WBQUEUEDEPTH, 4, writeback FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clk_en  in  1  global advance enable; all state holds while low.
- ReqValid  in  1  request valid.
- ReqReady  out  1  unit can accept a request.
- ReqIsStore  in  1  1 = store, 0 = load.
- ReqBase  in  DATABITWIDTH  base address.
- ReqOffset  in  DATABITWIDTH  signed offset.
- ReqStoreData  in  DATABITWIDTH  store data.
- ReqDestReg  in  REGADDRBITWIDTH  load destination register.
- MemWriteEn  out  1  memory write enable.
- MemAddr  out  DATABITWIDTH  memory address.
- MemDataOut  out  DATABITWIDTH  store data to memory.
- MemDataIn  in  DATABITWIDTH  combinational read data from memory.
- WbValid  out  1  writeback entry valid.
- WbReady  in  1  writeback consumer ready.
- WbDestReg  out  REGADDRBITWIDTH  writeback register index.
- WbData  out  DATABITWIDTH  load data.
- WbFault  out  1  load address was out of range.
- StoreFault  out  1  one-cycle pulse: a store was dropped for out-of-range address.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: request register empty, FIFO empty. ReqReady=1, MemWriteEn=0, MemAddr=0, MemDataOut=0, WbValid=0, WbDestReg=0, WbData=0, WbFault=0, StoreFault=0.
- Effective address: EA = ReqBase + ReqOffset, modulo 2^DATABITWIDTH (wraps, no carry out). It is computed at accept and stored in the request register.
- Range check: EA >= 1024 (any bit above bit 9 set) means out of range.
- Accept: occurs on a clock edge when ReqValid && ReqReady && clk_en. The request is latched into a single request register (RR).
- Memory drive: MemAddr = RR.EA and MemDataOut = RR.StoreData whenever RR is valid, else 0.
- MemWriteEn = RR.valid && RR.IsStore && in-range && clk_en. The memory has no enable of its own, so gating by clk_en here is mandatory.
- Store retire: a store leaves RR on the next enabled edge, so the memory write takes effect on that same edge. Out-of-range stores write nothing and pulse StoreFault for one cycle after that edge.
- Load retire: a load leaves RR on an enabled edge only if the FIFO can accept, i.e. not full, or full with a pop on the same edge.
  - Pushed entry: {RR.DestReg, MemDataIn, fault}.
  - Out-of-range loads push data 0 with fault=1.
- ReqReady = !RR.valid || RR retires this edge (combinational from FIFO state and WbReady). Back-to-back accepts at one per cycle must be sustained.
- Latency:
  - Load accepted at edge E0 is read from memory during the cycle after E0.
  - Its result is pushed at edge E1, so WbValid is seen after E1: 2 edges.
  - Store accepted at E0 writes memory at E1.
- Ordering: strictly in order. A load following a store to the same address reads the stored value, because the store commits at the edge the load enters RR.
- FIFO:
  - WbValid = !empty; WbDestReg, WbData and WbFault show the head entry.
  - Pop on an enabled edge with WbValid && WbReady.
  - Push and pop on the same edge when full is legal; occupancy is unchanged.
  - Pointers wrap modulo WBQUEUEDEPTH; a count of log2(depth)+1 bits distinguishes full from empty.
- clk_en low: no accept, retire, push or pop; MemWriteEn=0; all registers hold; StoreFault=0.
- Reset mid-operation: the RR entry and all FIFO entries are discarded immediately. A store in RR that has not reached its edge is never written.

Decomposition:
- Package fixed_memory_pkg holds:
  - MEMADDRBITS=10 and MEMWORDS=1024;
  - typedef mem_req_t {valid, is_store, ea, store_data, dest_reg};
  - typedef wb_entry_t {dest_reg, data, fault}.
- One sub-module, wb_fifo: a parameterised synchronous FIFO with depth, entry type, push, pop, full and empty, using async reset.

Test Plan:
- Store then load, back to back: store EA=0x0010 data 0xBEEF, then load same EA to r3 → MemWriteEn high for exactly one cycle; WbValid 2 edges after the load accept with WbDestReg=3, WbData=0xBEEF.
- Offset wrap: Base=0xFFFF, Offset=0x0002, store 0x1234 → write at address 0x0001. Base=0x0400, Offset=0 → StoreFault pulse, no write; a load there returns WbData=0, WbFault=1.
- Backpressure: WbReady=0, issue 6 loads with depth 4 → 4 entries queued, 1 in RR, ReqReady=0. Raise WbReady → results drain in issue order, and ReqReady returns the same cycle as the first pop.
- clk_en low for 3 cycles with RR holding a store and ReqValid=1 → no memory write, no accept, outputs frozen. The write occurs at the first enabled edge.
- Reset asserted asynchronously mid-cycle with RR=store and FIFO=2 entries → WbValid=0 and MemWriteEn=0 immediately; memory contents at the store address are unchanged.
